// File: rtl/sdram_port_pkg.sv
// Shared types and constants for the VGA/CPU port in front of the SDRAM controller.
// Holds the FSM state encoding, the burst geometry and the word-alignment mask.
package sdram_port_pkg;

    localparam int BURST_LEN = 32;
    localparam int ADDR_W    = 26;
    localparam int BEAT_W    = $clog2(BURST_LEN + 1);

    // Byte addresses are presented to the controller word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VGA_CMD  = 3'd1,
        ST_VGA_DATA = 3'd2,
        ST_VGA_DONE = 3'd3,
        ST_CPU_CMD  = 3'd4,
        ST_CPU_DATA = 3'd5
    } port_state_e;

    function automatic logic in_vga_state(input port_state_e s);
        return (s == ST_VGA_CMD) || (s == ST_VGA_DATA) || (s == ST_VGA_DONE);
    endfunction

endpackage

// File: rtl/sdram_port_arb.sv
// Grant logic between VGA bursts and CPU single accesses.
// VGA wins by default; a CPU request seen during a burst earns one turn before the next burst.
module sdram_port_arb (
    input  logic clock,
    input  logic reset_n,
    input  logic idle,
    input  logic in_vga,
    input  logic vga_request,
    input  logic cpu_request,
    input  logic cpu_hold,
    output logic grant_vga,
    output logic grant_cpu
);

    logic cpu_owed;
    logic cpu_req_eff;

    // The CPU keeps its request up during the cpu_ack cycle; that is not a new access.
    assign cpu_req_eff = cpu_request && !cpu_hold;

    always_comb begin
        grant_vga = 1'b0;
        grant_cpu = 1'b0;
        if (idle) begin
            if (vga_request && (!cpu_req_eff || !cpu_owed)) begin
                grant_vga = 1'b1;
            end else if (cpu_req_eff) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_owed <= 1'b0;
        end else if (grant_cpu) begin
            cpu_owed <= 1'b0;
        end else if (in_vga && cpu_request) begin
            cpu_owed <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_vga_port.sv
// Memory-side responder for the framebuffer read protocol: arbitrates VGA bursts and
// CPU single accesses into one SDRAM controller command stream and returns read data.
module sdram_vga_port #(
    parameter int BURST_LEN = sdram_port_pkg::BURST_LEN,
    parameter int ADDR_W    = sdram_port_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              vga_request,
    input  logic [ADDR_W-1:0] vga_address,
    output logic              vga_ack,
    output logic              vga_valid,
    output logic [31:0]       vga_rdata,
    output logic              vga_complete,

    input  logic              cpu_request,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_byte_en,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,

    output logic              sd_request,
    output logic              sd_write,
    output logic              sd_burst,
    output logic [ADDR_W-1:0] sd_address,
    output logic [31:0]       sd_wdata,
    output logic [3:0]        sd_byte_en,
    input  logic              sd_ack,
    input  logic              sd_rvalid,
    input  logic [31:0]       sd_rdata
);

    import sdram_port_pkg::*;

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    // Only the low alignment bits of the package mask are cleared, at any ADDR_W.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(~ALIGN_MASK);

    port_state_e      state, state_nxt;
    logic [CNT_W-1:0] beat_cnt;

    logic grant_vga, grant_cpu;
    logic load_vga, load_cpu;
    logic cmd_done;
    logic vga_beat, cpu_beat, cpu_wr_done;

    sdram_port_arb u_arb (
        .clock       (clock),
        .reset_n     (reset_n),
        .idle        (state == ST_IDLE),
        .in_vga      (in_vga_state(state)),
        .vga_request (vga_request),
        .cpu_request (cpu_request),
        .cpu_hold    (cpu_ack),
        .grant_vga   (grant_vga),
        .grant_cpu   (grant_cpu)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_vga    = 1'b0;
        load_cpu    = 1'b0;
        cmd_done    = 1'b0;
        vga_beat    = 1'b0;
        cpu_beat    = 1'b0;
        cpu_wr_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_vga) begin
                    load_vga  = 1'b1;
                    state_nxt = ST_VGA_CMD;
                end else if (grant_cpu) begin
                    load_cpu  = 1'b1;
                    state_nxt = ST_CPU_CMD;
                end
            end
            ST_VGA_CMD: begin
                if (sd_ack) begin
                    cmd_done  = 1'b1;
                    state_nxt = ST_VGA_DATA;
                end
            end
            ST_VGA_DATA: begin
                if (sd_rvalid) begin
                    vga_beat = 1'b1;
                    if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                        state_nxt = ST_VGA_DONE;
                    end
                end
            end
            ST_VGA_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_CPU_CMD: begin
                if (sd_ack) begin
                    cmd_done = 1'b1;
                    // sd_write still holds the latched CPU direction here.
                    if (sd_write) begin
                        cpu_wr_done = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        state_nxt   = ST_CPU_DATA;
                    end
                end
            end
            ST_CPU_DATA: begin
                if (sd_rvalid) begin
                    cpu_beat  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command side: registered one cycle after the grant, dropped on sd_ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sd_request <= 1'b0;
            sd_write   <= 1'b0;
            sd_burst   <= 1'b0;
            sd_address <= '0;
            sd_wdata   <= '0;
            sd_byte_en <= '0;
        end else if (load_vga) begin
            sd_request <= 1'b1;
            sd_write   <= 1'b0;
            sd_burst   <= 1'b1;
            sd_address <= vga_address & WORD_MASK;
            sd_wdata   <= '0;
            sd_byte_en <= '0;
        end else if (load_cpu) begin
            sd_request <= 1'b1;
            sd_write   <= cpu_write;
            sd_burst   <= 1'b0;
            sd_address <= cpu_address & WORD_MASK;
            sd_wdata   <= cpu_wdata;
            sd_byte_en <= cpu_byte_en;
        end else if (cmd_done) begin
            sd_request <= 1'b0;
        end
    end

    // Return side: every handshake pulse is one cycle after the event that causes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vga_ack      <= 1'b0;
            vga_valid    <= 1'b0;
            vga_rdata    <= '0;
            vga_complete <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            beat_cnt     <= '0;
        end else begin
            vga_ack      <= load_vga;
            vga_valid    <= vga_beat;
            vga_complete <= (state == ST_VGA_DONE);
            cpu_ack      <= cpu_wr_done || cpu_beat;
            if (vga_beat) begin
                vga_rdata <= sd_rdata;
            end
            if (cpu_beat) begin
                cpu_rdata <= sd_rdata;
            end
            if (load_vga) begin
                beat_cnt <= '0;
            end else if (vga_beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdram_vga_port.sv
// Directed bench for sdram_vga_port: bursts, gapped beats, contention, CPU write, reset.
module tb_sdram_vga_port;

    logic        clock;
    logic        reset_n;
    logic        vga_request;
    logic [25:0] vga_address;
    logic        vga_ack;
    logic        vga_valid;
    logic [31:0] vga_rdata;
    logic        vga_complete;
    logic        cpu_request;
    logic        cpu_write;
    logic [25:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_en;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        sd_request;
    logic        sd_write;
    logic        sd_burst;
    logic [25:0] sd_address;
    logic [31:0] sd_wdata;
    logic [3:0]  sd_byte_en;
    logic        sd_ack;
    logic        sd_rvalid;
    logic [31:0] sd_rdata;

    int total = 0;
    int bad   = 0;
    int vga_ack_cnt = 0;
    int ack_before;

    sdram_vga_port dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .vga_request  (vga_request),
        .vga_address  (vga_address),
        .vga_ack      (vga_ack),
        .vga_valid    (vga_valid),
        .vga_rdata    (vga_rdata),
        .vga_complete (vga_complete),
        .cpu_request  (cpu_request),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_byte_en  (cpu_byte_en),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .sd_request   (sd_request),
        .sd_write     (sd_write),
        .sd_burst     (sd_burst),
        .sd_address   (sd_address),
        .sd_wdata     (sd_wdata),
        .sd_byte_en   (sd_byte_en),
        .sd_ack       (sd_ack),
        .sd_rvalid    (sd_rvalid),
        .sd_rdata     (sd_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (vga_ack) vga_ack_cnt <= vga_ack_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vga_ack"},      vga_ack,      32'd0);
        chk({tag, "_vga_valid"},    vga_valid,    32'd0);
        chk({tag, "_vga_rdata"},    vga_rdata,    32'd0);
        chk({tag, "_vga_complete"}, vga_complete, 32'd0);
        chk({tag, "_cpu_ack"},      cpu_ack,      32'd0);
        chk({tag, "_cpu_rdata"},    cpu_rdata,    32'd0);
        chk({tag, "_sd_request"},   sd_request,   32'd0);
        chk({tag, "_sd_write"},     sd_write,     32'd0);
        chk({tag, "_sd_burst"},     sd_burst,     32'd0);
        chk({tag, "_sd_address"},   {6'd0, sd_address}, 32'd0);
        chk({tag, "_sd_wdata"},     sd_wdata,     32'd0);
        chk({tag, "_sd_byte_en"},   {28'd0, sd_byte_en}, 32'd0);
    endtask

    // Runs one VGA burst from request up to the cycle vga_complete is high.
    task automatic run_burst(input string tag, input logic [25:0] addr, input int gap,
                             input int drop_beat, input int cpu_beat, input bit spurious,
                             input logic [31:0] base);
        vga_request = 1'b1;
        vga_address = addr;
        tick();
        chk({tag, "_ack"},     vga_ack,    32'd1);
        chk({tag, "_sd_req"},  sd_request, 32'd1);
        chk({tag, "_sd_burst"}, sd_burst,  32'd1);
        chk({tag, "_sd_write"}, sd_write,  32'd0);
        chk({tag, "_sd_addr"}, {6'd0, sd_address}, {6'd0, addr[25:2], 2'b00});
        if (drop_beat < 0) vga_request = 1'b0;
        if (spurious) begin
            sd_rvalid = 1'b1;
            sd_rdata  = 32'hbad0bad0;
            tick();
            sd_rvalid = 1'b0;
            chk({tag, "_cmd_hold"},   sd_request, 32'd1);
            chk({tag, "_spur_valid"}, vga_valid,  32'd0);
            chk({tag, "_ack_once"},   vga_ack,    32'd0);
        end
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk({tag, "_sd_req_drop"}, sd_request, 32'd0);
        chk({tag, "_ack_pulse"},   vga_ack,    32'd0);
        for (int i = 0; i < 32; i++) begin
            if (i == drop_beat) vga_request = 1'b0;
            if (i == cpu_beat) begin
                cpu_request = 1'b1;
                cpu_write   = 1'b0;
                cpu_address = 26'h100;
            end
            sd_rvalid = 1'b1;
            sd_rdata  = base + 32'(i);
            tick();
            sd_rvalid = 1'b0;
            chk({tag, "_valid"}, vga_valid,    32'd1);
            chk({tag, "_rdata"}, vga_rdata,    base + 32'(i));
            chk({tag, "_early"}, vga_complete, 32'd0);
            if (i != 31) begin
                for (int g = 1; g < gap; g++) begin
                    tick();
                    chk({tag, "_gap_valid"}, vga_valid,    32'd0);
                    chk({tag, "_gap_cmpl"},  vga_complete, 32'd0);
                end
            end
        end
        tick();
        chk({tag, "_complete"},   vga_complete, 32'd1);
        chk({tag, "_valid_done"}, vga_valid,    32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        vga_request = 1'b0;
        vga_address = '0;
        cpu_request = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        cpu_byte_en = '0;
        sd_ack      = 1'b0;
        sd_rvalid   = 1'b0;
        sd_rdata    = '0;
        repeat (3) tick();
        chk_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // Single burst, zero-wait controller
        ack_before = vga_ack_cnt;
        run_burst("b1", 26'h3f80000, 1, -1, -1, 1'b0, 32'ha0000000);
        tick();
        chk("b1_cmpl_pulse", vga_complete, 32'd0);
        chk("b1_ack_count", 32'(vga_ack_cnt - ack_before), 32'd1);

        // Stray beat while idle is ignored
        sd_rvalid = 1'b1;
        sd_rdata  = 32'h55555555;
        tick();
        sd_rvalid = 1'b0;
        chk("idle_rv_valid", vga_valid, 32'd0);
        chk("idle_rv_cpu",   cpu_ack,   32'd0);
        tick();

        // Gapped beats, unaligned address, spurious beat during command phase
        run_burst("gap", 26'h0001237, 3, -1, -1, 1'b1, 32'hb0000000);
        tick();
        chk("gap_cmpl_pulse", vga_complete, 32'd0);

        // Contention: CPU read raised mid-burst, VGA re-requests immediately
        run_burst("cont", 26'h0200000, 1, -1, 5, 1'b0, 32'hc0000000);
        vga_request = 1'b1;
        vga_address = 26'h0300000;
        tick();
        chk("cont_cpu_req",   sd_request, 32'd1);
        chk("cont_cpu_burst", sd_burst,   32'd0);
        chk("cont_cpu_wr",    sd_write,   32'd0);
        chk("cont_cpu_addr",  {6'd0, sd_address}, 32'h100);
        chk("cont_no_vga",    vga_ack,    32'd0);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("cont_cmd_drop", sd_request, 32'd0);
        chk("cont_no_ack",   cpu_ack,    32'd0);
        sd_rvalid = 1'b1;
        sd_rdata  = 32'h12345678;
        tick();
        sd_rvalid = 1'b0;
        chk("cont_cpu_ack",   cpu_ack,   32'd1);
        chk("cont_cpu_rdata", cpu_rdata, 32'h12345678);
        cpu_request = 1'b0;
        run_burst("cont2", 26'h0300000, 1, -1, -1, 1'b0, 32'hd0000000);
        tick();

        // CPU write
        cpu_request = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 26'h0000204;
        cpu_wdata   = 32'hdeadbeef;
        cpu_byte_en = 4'b0011;
        tick();
        chk("wr_req",   sd_request, 32'd1);
        chk("wr_write", sd_write,   32'd1);
        chk("wr_burst", sd_burst,   32'd0);
        chk("wr_addr",  {6'd0, sd_address}, 32'h204);
        chk("wr_data",  sd_wdata,   32'hdeadbeef);
        chk("wr_be",    {28'd0, sd_byte_en}, 32'h3);
        chk("wr_no_ack", cpu_ack,   32'd0);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("wr_ack",      cpu_ack,    32'd1);
        chk("wr_req_drop", sd_request, 32'd0);
        tick();
        chk("wr_ack_pulse", cpu_ack,    32'd0);
        chk("wr_no_regrant", sd_request, 32'd0);
        cpu_request = 1'b0;
        cpu_write   = 1'b0;
        tick();

        // vga_request dropped at beat 10 (held through ack)
        ack_before = vga_ack_cnt;
        run_burst("drop", 26'h0040000, 1, 10, -1, 1'b0, 32'he0000000);
        tick();
        chk("drop_cmpl_pulse", vga_complete, 32'd0);
        chk("drop_ack_count", 32'(vga_ack_cnt - ack_before), 32'd1);
        tick();

        // Reset asserted at beat 5
        vga_request = 1'b1;
        vga_address = 26'h0080000;
        tick();
        vga_request = 1'b0;
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sd_rvalid = 1'b1;
            sd_rdata  = 32'hf0000000 + 32'(i);
            tick();
        end
        chk("mid_valid", vga_valid, 32'd1);
        chk("mid_rdata", vga_rdata, 32'hf0000004);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        sd_rvalid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", sd_request, 32'd0);
        run_burst("rst2", 26'h0080000, 1, -1, -1, 1'b0, 32'h11110000);
        tick();
        chk("rst2_cmpl_pulse", vga_complete, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_vga_port.md
# sdram_vga_port

Memory-side responder for the display's framebuffer read protocol (request / address / ack / valid / complete). It accepts 32-word burst read requests from the VGA output block and single-word CPU accesses, arbitrates between them, and drives one command stream into the SDRAM controller. Streamed read data is returned to the VGA block one word per `vga_valid` pulse, and the burst is closed with `vga_complete`.

## Interface
- `BURST_LEN`, 32: words returned per VGA request.
- `ADDR_W`, 26: byte address width.
- `clock` in 1: 100 MHz system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `vga_request` in 1: burst request, held high until `vga_ack`.
- `vga_address` in 26: byte address of first word; bits [1:0] ignored.
- `vga_ack` out 1: one-cycle pulse, request accepted.
- `vga_valid` out 1: one-cycle pulse per returned word.
- `vga_rdata` out 32: data, qualified by `vga_valid`.
- `vga_complete` out 1: one-cycle pulse, burst finished.
- `cpu_request` in 1: single access, held until `cpu_ack`.
- `cpu_write` in 1: 1 = write, 0 = read.
- `cpu_address` in 26: byte address.
- `cpu_wdata` in 32: write data.
- `cpu_byte_en` in 4: write byte enables.
- `cpu_ack` out 1: one-cycle pulse, access done; `cpu_rdata` valid for reads.
- `cpu_rdata` out 32: read data.
- `sd_request` out 1: command to controller, held until `sd_ack`.
- `sd_write` out 1: write command.
- `sd_burst` out 1: 1 = BURST_LEN-word read, 0 = single word.
- `sd_address` out 26: command address, word aligned.
- `sd_wdata` out 32: write data.
- `sd_byte_en` out 4: byte enables.
- `sd_ack` in 1: command accepted this cycle.
- `sd_rvalid` in 1: read word returned. Beats may be non-contiguous.
- `sd_rdata` in 32: read data.

## Operation
- States: IDLE, VGA_CMD, VGA_DATA, VGA_DONE, CPU_CMD, CPU_DATA.
- IDLE grant rules:
  - If `vga_request` is high and (`cpu_request` is low or `cpu_owed` = 0), go to VGA_CMD. Pulse `vga_ack` next cycle and latch the address with [1:0] forced to 0.
  - Otherwise, if `cpu_request` is high, go to CPU_CMD and latch all CPU inputs.
- `cpu_owed` fairness bit:
  - Set when `cpu_request` is seen high during any VGA state.
  - Cleared on CPU grant.
  - Effect: one CPU access is served between consecutive VGA bursts. VGA otherwise has priority.
- VGA_CMD: `sd_request`=1, `sd_burst`=1, `sd_write`=0. On `sd_ack`, drop `sd_request` and go to VGA_DATA with beat counter = 0.
- VGA_DATA:
  - Each `sd_rvalid` registers `sd_rdata` to `vga_rdata`, pulses `vga_valid` next cycle, and increments the beat counter (6 bits).
  - On the beat that makes the count BURST_LEN, go to VGA_DONE.
- VGA_DONE: pulse `vga_complete` for one cycle, then return to IDLE.
- CPU_CMD: `sd_request`=1, `sd_burst`=0, with `sd_write`, `sd_wdata`, `sd_byte_en` from the latched values. On `sd_ack`:
  - Write: pulse `cpu_ack` next cycle, go to IDLE.
  - Read: go to CPU_DATA.
- CPU_DATA: on `sd_rvalid`, register the data to `cpu_rdata`, pulse `cpu_ack` next cycle, go to IDLE.
- Boundary rules:
  - `sd_rvalid` in IDLE, VGA_CMD or CPU_CMD is ignored.
  - `vga_request` dropping during a burst does not abort it; all BURST_LEN words are still delivered.
  - `vga_request` still high in the cycle `vga_ack` pulses must not start a second burst.
  - Address arithmetic is not performed; the controller increments within the burst.
- Reset (asserted at any time, including mid-burst):
  - State IDLE, counter 0, `cpu_owed` 0.
  - All outputs 0, including data buses.

## Timing
- Grant to `sd_request`: 1 cycle (registered).
- `vga_ack`: the cycle after the IDLE grant decision.
- `sd_rvalid` to `vga_valid`/`cpu_ack`: 1 cycle.
- Last `vga_valid` to `vga_complete`: 1 cycle. Complete to next possible grant: 1 cycle.
- Minimum VGA burst: BURST_LEN + 4 cycles with zero-wait controller.
- Throughput: one beat per cycle sustained.

## Structure
- Package `sdram_port_pkg`: state enum, `BURST_LEN`, beat-counter width, alignment mask.
- Sub-module `sdram_port_arb`: combinational grant plus the `cpu_owed` register. Datapath and FSM stay in the top.

## Test plan
- **Single VGA burst, zero-wait controller.** Stimulus: request at 0x3f80000, 32 contiguous beats. Required response: exactly one `vga_ack`, 32 `vga_valid` in order, `vga_complete` one cycle after beat 32, `sd_address`=0x3f80000.
- **Gapped beats.** Stimulus: `sd_rvalid` every 3rd cycle. Required response: 32 valids with data order preserved, no early `vga_complete`.
- **Contention.** Stimulus: CPU read at 0x100 raised during a burst while VGA re-requests immediately. Required response: CPU is granted before the second burst; `cpu_rdata` equals the returned word.
- **CPU write.** Stimulus: data 0xdeadbeef, byte_en 4'b0011. Required response: `sd_write`=1 with matching data/enables; `cpu_ack` one cycle after `sd_ack`; no `sd_rvalid` wait.
- **`vga_request` dropped mid-burst.** Stimulus: drop `vga_request` at beat 10. Required response: all 32 beats and `vga_complete` still delivered.
- **Reset mid-burst.** Stimulus: assert `reset_n` low at beat 5. Required response: all outputs 0 immediately. After release, a new request restarts cleanly at beat 0.
